serpent_key_load_ctrl: RTL and testbench
========================================

Name: serpent_key_load_ctrl

Overview:
- Sequences `key_schedule_slow` to expand XTS keys into the subkey RAM. The two requesters are slot 0 (data key K1) and slot 1 (tweak key K2).
- Arbitrates between the two requesters round-robin and captures the granted key. Pulses the schedule's begin, then writes the 33 streamed subkeys into a per-slot region of the subkey RAM.
- Reports per-slot readiness to the XTS datapath and flags schedule timeouts or bad addresses.

Parameters:
- NUM_SUBKEYS, 33, subkeys per key; load completes after this many writes.
- TIMEOUT, 2047, max cycles from begin pulse to last subkey before abort.
- ADDR_W, 6, width of the schedule's subkey address.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  synchronous active-high reset.
- i_req  in  2  level load request per slot; held until acked.
- i_key0  in  256  slot 0 key; sampled on grant.
- i_key1  in  256  slot 1 key; sampled on grant.
- o_ack  out  2  one-cycle grant pulse per slot.
- o_busy  out  1  high from grant until return to IDLE.
- o_slot_ready  out  2  slot's RAM region holds a complete subkey set.
- o_error  out  1  sticky fault flag; cleared on next grant.
- o_ks_begin  out  1  one-cycle start to the key schedule.
- o_ks_key  out  256  captured key to the key schedule.
- i_ks_subkey  in  128  subkey from the schedule.
- i_ks_address  in  ADDR_W  subkey index from the schedule.
- i_ks_valid  in  1  subkey/address valid.
- o_ram_we  out  1  subkey RAM write enable.
- o_ram_addr  out  ADDR_W+1  RAM address = {slot, index}.
- o_ram_wdata  out  128  RAM write data.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer = slot 0 preferred. o_ks_key and the key register clear to 0. Reset mid-load aborts immediately: no further RAM writes, o_slot_ready = 00.
- States: IDLE -> GRANT -> START -> COLLECT -> IDLE.
- IDLE, both req high: grant the slot the rr pointer prefers.
- IDLE, single req high: grant that slot.
- IDLE, no req: stay.
- GRANT (1 cycle):
  - capture i_keyN into the key register;
  - o_ack[g] = 1;
  - clear o_slot_ready[g] and o_error;
  - o_busy = 1;
  - rr pointer moves to prefer the other slot.
- START (1 cycle): o_ks_begin = 1, o_ks_key = captured key (stable until the next grant). Reset the write count and the timeout counter.
- COLLECT, each cycle i_ks_valid = 1, address in range (i_ks_address < NUM_SUBKEYS):
  - next cycle o_ram_we = 1, o_ram_addr = {g, i_ks_address}, o_ram_wdata = i_ks_subkey (1-cycle registered latency);
  - count increments.
- COLLECT, i_ks_valid = 1 with address >= NUM_SUBKEYS: no write, o_error = 1, count unchanged, continue.
- Completion: the cycle the NUM_SUBKEYS-th write issues, go to IDLE. o_slot_ready[g] = 1 and o_busy = 0 on the next cycle.
- Timeout: counter increments each cycle in COLLECT. On reaching TIMEOUT without completion:
  - o_error = 1;
  - o_slot_ready[g] stays 0;
  - go to IDLE;
  - later i_ks_valid is ignored (no RAM writes in IDLE).
- i_ks_valid outside COLLECT is ignored.
- Requests while busy: held, not acked, re-arbitrated in IDLE.
- Reload of an already-ready slot: that slot's ready drops at grant. The other slot's ready is unaffected.
- Duplicate addresses are written again and counted; the schedule guarantees uniqueness.

Test Plan:
- Reset, i_req = 01, i_key0 = 256'h00112233445566778899aabbccddeeffffeeddccbbaa99887766554433221100, reference schedule model:
  - o_ack = 01 for 1 cycle, then o_ks_begin = 1 for 1 cycle with o_ks_key = key;
  - 33 writes, o_ram_addr 0x00..0x20, data matching the model;
  - o_slot_ready = 01 one cycle after the last write; o_error = 0.
- After reset, i_req = 11 held:
  - slot 0 acked first (addr 0x00..0x20), then slot 1 acked (addr 0x40..0x60);
  - final o_slot_ready = 11.
- Round-robin: after slot 1 load, raise i_req = 11 -> slot 0 granted, o_slot_ready goes 11 -> 10 at grant, then 11 at completion.
- Timeout: model stops after 10 valid subkeys -> exactly 10 writes, o_error = 1 at TIMEOUT cycles after begin, o_slot_ready[0] = 0, o_busy = 0. Next grant clears o_error.
- Bad address: model emits i_ks_address = 6'd40 once among 33 valid indices -> no write for it, o_error = 1, load still completes after 33 good writes.
- Reset asserted mid-COLLECT (after 5 writes) -> next cycle o_ram_we = 0, o_slot_ready = 00, o_busy = 0. Remaining model valids produce no writes.

Source files
------------

// File: rtl/serpent_key_load_ctrl.sv
// -----------------------------------------------------------------------------
// serpent_key_load_ctrl
//
// Loads XTS keys into the subkey RAM through key_schedule_slow. Two requesters
// (slot 0 = data key K1, slot 1 = tweak key K2) are arbitrated round-robin.
// The granted key is captured and handed to the schedule with a begin pulse.
// The streamed subkeys are then written into that slot's RAM half, at address
// {slot, index}.
//
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_req[1:0]                 level load request per slot, held until acked
//   i_key0, i_key1             slot keys, sampled on grant
//   o_ack[1:0]                 one-cycle grant pulse
//   o_busy                     high from grant until back in IDLE
//   o_slot_ready[1:0]          slot region holds a complete subkey set
//   o_error                    sticky timeout / bad-address flag, cleared on grant
//   o_ks_begin, o_ks_key       start pulse and key to the key schedule
//   i_ks_subkey/address/valid  subkey stream from the key schedule
//   o_ram_we/addr/wdata        subkey RAM write port (1-cycle registered)
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for a request; RAM writes and schedule output ignored
// GRANT   | ack pulse, key captured, slot ready and error cleared
// START   | begin pulse to the schedule; write count and timer reset
// COLLECT | writing streamed subkeys until the set is complete or timeout
// -----------------------------------------------------------------------------
module serpent_key_load_ctrl #(
  parameter int NUM_SUBKEYS = 33,
  parameter int TIMEOUT     = 2047,
  parameter int ADDR_W      = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req,
  input  logic [255:0]      i_key0,
  input  logic [255:0]      i_key1,
  output logic [1:0]        o_ack,
  output logic              o_busy,
  output logic [1:0]        o_slot_ready,
  output logic              o_error,
  output logic              o_ks_begin,
  output logic [255:0]      o_ks_key,
  input  logic [127:0]      i_ks_subkey,
  input  logic [ADDR_W-1:0] i_ks_address,
  input  logic              i_ks_valid,
  output logic              o_ram_we,
  output logic [ADDR_W:0]   o_ram_addr,
  output logic [127:0]      o_ram_wdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_START   = 2'd2;
  localparam logic [1:0] S_COLLECT = 2'd3;

  localparam int CNT_W = $clog2(NUM_SUBKEYS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W:0]  NUM_A    = (ADDR_W + 1)'(NUM_SUBKEYS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SUBKEYS);
  // Down-counter loaded so that the abort is visible exactly TIMEOUT cycles
  // after the begin pulse.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic              r_slot;
  logic              r_rr;       // slot preferred when both request
  logic [1:0]        r_ack;
  logic              r_busy;
  logic [1:0]        r_ready;
  logic              r_error;
  logic              r_ks_begin;
  logic [255:0]      r_key;
  logic [CNT_W-1:0]  r_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_we;
  logic [ADDR_W:0]   r_addr;
  logic [127:0]      r_wdata;

  logic w_gnt_slot;
  logic w_in_range;
  logic w_done;
  logic w_timeout;
  logic w_collect;
  logic w_accept;
  logic w_bad;

  assign w_gnt_slot = (i_req == 2'b11) ? r_rr : i_req[1];
  assign w_in_range = ({1'b0, i_ks_address} < NUM_A);

  // The last write is on the RAM port in the cycle w_done is seen; completion
  // takes priority over a timeout landing in the same cycle.
  assign w_done    = (r_state == S_COLLECT) && (r_cnt == CNT_LAST);
  assign w_timeout = (r_state == S_COLLECT) && !w_done && (r_tmo == TMO_W'(1));
  assign w_collect = (r_state == S_COLLECT) && !w_done && !w_timeout;
  assign w_accept  = w_collect && i_ks_valid && w_in_range;
  assign w_bad     = w_collect && i_ks_valid && !w_in_range;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_slot     <= 1'b0;
      r_rr       <= 1'b0;
      r_ack      <= 2'b00;
      r_busy     <= 1'b0;
      r_ready    <= 2'b00;
      r_error    <= 1'b0;
      r_ks_begin <= 1'b0;
      r_key      <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_ack      <= 2'b00;
      r_ks_begin <= 1'b0;
      r_we       <= w_accept;
      if (w_accept) begin
        r_addr  <= {r_slot, i_ks_address};
        r_wdata <= i_ks_subkey;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_bad) begin
        r_error <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_state             <= S_GRANT;
            r_slot              <= w_gnt_slot;
            r_rr                <= ~w_gnt_slot;
            r_ack               <= w_gnt_slot ? 2'b10 : 2'b01;
            r_key               <= w_gnt_slot ? i_key1 : i_key0;
            r_ready[w_gnt_slot] <= 1'b0;
            r_error             <= 1'b0;
            r_busy              <= 1'b1;
          end
        end
        S_GRANT: begin
          r_ks_begin <= 1'b1;
          r_state    <= S_START;
        end
        S_START: begin
          r_cnt   <= '0;
          r_tmo   <= TMO_LOAD;
          r_state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (w_done) begin
            r_ready[r_slot] <= 1'b1;
            r_busy          <= 1'b0;
            r_state         <= S_IDLE;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo - TMO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_busy       = r_busy;
  assign o_slot_ready = r_ready;
  assign o_error      = r_error;
  assign o_ks_begin   = r_ks_begin;
  assign o_ks_key     = r_key;
  assign o_ram_we     = r_we;
  assign o_ram_addr   = r_addr;
  assign o_ram_wdata  = r_wdata;

endmodule

// File: tb/tb_serpent_key_load_ctrl.sv
module tb_serpent_key_load_ctrl;

  localparam int NUM = 33;
  localparam int TMO = 2047;

  localparam logic [255:0] K0 =
    256'h00112233445566778899aabbccddeeffffeeddccbbaa99887766554433221100;
  localparam logic [255:0] K1 =
    256'hfedcba98765432100123456789abcdef0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [255:0] K2 =
    256'h3141592653589793238462643383279502884197169399375105820974944592;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [1:0]   i_req;
  logic [255:0] i_key0, i_key1;
  logic [1:0]   o_ack;
  logic         o_busy;
  logic [1:0]   o_slot_ready;
  logic         o_error;
  logic         o_ks_begin;
  logic [255:0] o_ks_key;
  logic [127:0] i_ks_subkey;
  logic [5:0]   i_ks_address;
  logic         i_ks_valid;
  logic         o_ram_we;
  logic [6:0]   o_ram_addr;
  logic [127:0] o_ram_wdata;

  always #5 clk = ~clk;

  serpent_key_load_ctrl dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_req        (i_req),
    .i_key0       (i_key0),
    .i_key1       (i_key1),
    .o_ack        (o_ack),
    .o_busy       (o_busy),
    .o_slot_ready (o_slot_ready),
    .o_error      (o_error),
    .o_ks_begin   (o_ks_begin),
    .o_ks_key     (o_ks_key),
    .i_ks_subkey  (i_ks_subkey),
    .i_ks_address (i_ks_address),
    .i_ks_valid   (i_ks_valid),
    .o_ram_we     (o_ram_we),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wdata  (o_ram_wdata)
  );

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic [1:0] exp_ready;

  typedef struct {
    logic [6:0]   addr;
    logic [127:0] data;
  } wr_t;
  wr_t sb[$];
  wr_t mon_e;

  typedef struct {
    bit           do_reset;
    logic [1:0]   req_set;
    int           slot;
    logic [255:0] k0;
    logic [255:0] k1;
    logic [1:0]   exp_ready;
  } vec_t;
  vec_t vecs[5];

  // Stand-in key schedule: deterministic per-key, per-index subkey.
  function automatic logic [127:0] sk(input logic [255:0] k, input int idx);
    logic [255:0] r;
    int sh;
    sh = (idx * 7) % 256;
    if (sh == 0) r = k;
    else r = (k << sh) | (k >> (256 - sh));
    return r[127:0] ^ r[255:128] ^ {4{32'(idx) * 32'h9E3779B9}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_ram_we === 1'b1) begin
      writes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL ram_write unexpected addr=%h data=%h", o_ram_addr, o_ram_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (o_ram_addr !== mon_e.addr || o_ram_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL ram_write got addr=%h data=%h want addr=%h data=%h",
                   o_ram_addr, o_ram_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic do_reset();
    i_rst = 1'b1;
    i_req = 2'b00;
    i_ks_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", o_ack, 2'b00);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_slot_ready, 2'b00);
    chk("rst_error", o_error, 1'b0);
    chk("rst_ks_begin", o_ks_begin, 1'b0);
    chk("rst_ks_key", o_ks_key, 256'h0);
    chk("rst_ram_we", o_ram_we, 1'b0);
    chk("rst_ram_addr", o_ram_addr, 7'h0);
    chk("rst_ram_wdata", o_ram_wdata, 128'h0);
    i_rst = 1'b0;
    exp_ready = 2'b00;
  endtask

  // mode 0: complete load, 1: schedule stalls -> timeout, 2: reset after 5 writes
  task automatic run_load(input int slot, input int n_good, input int bad_pos, input int mode);
    logic [1:0]   oh;
    logic [255:0] key;
    bit           got;
    int           nvalid, k, w0;
    wr_t          e;
    oh  = (slot == 1) ? 2'b10 : 2'b01;
    key = (slot == 1) ? i_key1 : i_key0;
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (o_ack != 2'b00) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_wait no grant within 40 cycles, want ack %b", oh);
      return;
    end
    chk("ack", o_ack, oh);
    chk("busy_at_grant", o_busy, 1'b1);
    chk("error_cleared_at_grant", o_error, 1'b0);
    chk("ready_at_grant", o_slot_ready, exp_ready & ~oh);
    i_req[slot] = 1'b0;
    exp_ready = exp_ready & ~oh;
    @(negedge clk);
    chk("ks_begin", o_ks_begin, 1'b1);
    chk("ks_key", o_ks_key, key);
    chk("ack_pulse", o_ack, 2'b00);
    w0 = writes;
    nvalid = n_good + ((bad_pos >= 0) ? 1 : 0);
    k = 0;
    for (int i = 0; i < nvalid; i++) begin
      @(negedge clk);
      if (i == 0) chk("ks_begin_pulse", o_ks_begin, 1'b0);
      if (mode == 2 && i == 6) begin
        chk("midrst_ram_we", o_ram_we, 1'b0);
        chk("midrst_ready", o_slot_ready, 2'b00);
        chk("midrst_busy", o_busy, 1'b0);
        i_rst = 1'b0;
        exp_ready = 2'b00;
      end
      if (mode == 2 && i == 5) i_rst = 1'b1;
      i_ks_valid = 1'b1;
      if (i == bad_pos) begin
        i_ks_address = 6'd40;
        i_ks_subkey  = {4{$urandom}};
      end else begin
        i_ks_address = 6'(k);
        i_ks_subkey  = sk(key, k);
        if (mode != 2 || i < 5) begin
          e.addr = {oh[1], 6'(k)};
          e.data = i_ks_subkey;
          sb.push_back(e);
        end
        k++;
      end
    end
    @(negedge clk);
    i_ks_valid = 1'b0;
    if (mode == 0) begin
      chk("busy_last_write", o_busy, 1'b1);
      chk("ready_last_write", o_slot_ready, exp_ready);
      @(negedge clk);
      exp_ready = exp_ready | oh;
      chk("ready_done", o_slot_ready, exp_ready);
      chk("busy_done", o_busy, 1'b0);
      chk("error_done", o_error, (bad_pos >= 0) ? 1'b1 : 1'b0);
      chk("write_count", 256'(writes - w0), 256'(n_good));
    end else if (mode == 1) begin
      repeat (TMO - 1 - (nvalid + 1)) @(negedge clk);
      chk("tmo_busy_before", o_busy, 1'b1);
      chk("tmo_error_before", o_error, 1'b0);
      @(negedge clk);
      chk("tmo_error", o_error, 1'b1);
      chk("tmo_busy", o_busy, 1'b0);
      chk("tmo_ready", o_slot_ready, exp_ready);
      for (int i = 0; i < 3; i++) begin
        i_ks_valid   = 1'b1;
        i_ks_address = 6'(10 + i);
        i_ks_subkey  = sk(key, 10 + i);
        @(negedge clk);
      end
      i_ks_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("tmo_write_count", 256'(writes - w0), 256'(n_good));
    end else begin
      chk("midrst_write_count", 256'(writes - w0), 256'd5);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_req = 2'b00; i_key0 = '0; i_key1 = '0;
    i_ks_subkey = '0; i_ks_address = '0; i_ks_valid = 1'b0;
    exp_ready = 2'b00;

    vecs[0] = '{1'b1, 2'b01, 0, K0, K1, 2'b01};
    vecs[1] = '{1'b1, 2'b11, 0, K0, K1, 2'b01};
    vecs[2] = '{1'b0, 2'b00, 1, K0, K1, 2'b11};
    vecs[3] = '{1'b0, 2'b11, 0, K2, K1, 2'b11};
    vecs[4] = '{1'b0, 2'b00, 1, K2, K0, 2'b11};

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].do_reset) do_reset();
      i_key0 = vecs[v].k0;
      i_key1 = vecs[v].k1;
      i_req  = i_req | vecs[v].req_set;
      run_load(vecs[v].slot, NUM, -1, 0);
      chk("ready_vec", o_slot_ready, vecs[v].exp_ready);
    end

    i_key0 = K1 ^ K2;
    i_req[0] = 1'b1;
    run_load(0, NUM, 17, 0);
    chk("bad_error_sticky", o_error, 1'b1);

    i_key0 = K0;
    i_req[0] = 1'b1;
    run_load(0, 10, -1, 1);
    chk("tmo_ready_final", o_slot_ready, 2'b10);

    i_req[0] = 1'b1;
    run_load(0, NUM, -1, 0);
    chk("reload_error", o_error, 1'b0);

    i_key1 = K2;
    i_req[1] = 1'b1;
    run_load(1, NUM, -1, 2);
    repeat (3) @(negedge clk);
    chk("sb_drained", 256'(sb.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
